// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO absorbs core writes and a
// baud-rate FSM shifts each byte out LSB first on TXD, which idles high.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          clr_ovf,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          tx_idle,
    output logic                          TXD
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          idle_q, idle_d;
    logic          push_s, pop_s, drop_s;

    // FIFO bookkeeping: push/pop decisions, occupancy, pointers and sticky overflow
    always_comb begin
        push_s   = wr_en && !full_q;
        drop_s   = wr_en && full_q;
        pop_s    = (state_q == S_IDLE) && (count_q != CNT_ZERO);
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_FULL);
        // A dropped write outranks a simultaneous clear so no overflow is ever lost
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Serialiser next-state; TXD is driven from the pre-edge state, one cycle behind it
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = 1'b1;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (pop_s) begin
                    sh_d    = mem_q[rd_ptr_q];
                    baud_d  = BAUD_ZERO;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                txd_d = 1'b0;
                if (baud_q == BAUD_LAST) begin
                    baud_d  = BAUD_ZERO;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                txd_d = sh_q[0];
                if (baud_q == BAUD_LAST) begin
                    baud_d = BAUD_ZERO;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (baud_q == BAUD_LAST) begin
                    baud_d  = BAUD_ZERO;
                    state_d = S_IDLE;
                end else begin
                    baud_d  = baud_q + BAUD_ONE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        idle_d = (count_d == CNT_ZERO) && (state_d == S_IDLE);
    end

    // FIFO storage; contents need no reset because the count guards every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            baud_q   <= BAUD_ZERO;
            bit_q    <= 3'd0;
            sh_q     <= 8'h00;
            txd_q    <= 1'b1;
            idle_q   <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            txd_q    <= txd_d;
            idle_q   <= idle_d;
        end
    end

    assign full     = full_q;
    assign level    = count_q;
    assign overflow = ovf_q;
    assign tx_idle  = idle_q;
    assign TXD      = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-position reference model checked every
// cycle, a vector table for the burst/overflow case, and directed corner sequences.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_ovf;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          tx_idle;
    logic          TXD;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit         wr;
        logic [7:0] data;
        bit         clr;
        int         e_level;
        bit         e_full;
        bit         e_ovf;
    } vec_t;

    vec_t tbl[9];
    bit   a5_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // reference model: queue of pending bytes plus position inside the current frame
    byte unsigned mq[$];
    bit           m_busy = 1'b0;
    int           m_cnt  = 0;
    logic [7:0]   m_cur  = 8'h00;
    bit           m_ovf  = 1'b0;
    bit           m_txd  = 1'b1;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .level    (level),
        .overflow (overflow),
        .tx_idle  (tx_idle),
        .TXD      (TXD)
    );

    always #5 clk = ~clk;

    function automatic bit frame_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        else if (slot <= 8) return b[slot-1];
        else return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit was_full;
        bit do_pop;
        cyc++;
        if (reset) begin
            mq.delete();
            m_busy = 1'b0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_txd  = 1'b1;
        end else begin
            m_txd    = m_busy ? frame_bit(m_cur, m_cnt / CPB) : 1'b1;
            was_full = (mq.size() == DEPTH);
            do_pop   = !m_busy && (mq.size() != 0);
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 10 * CPB) m_busy = 1'b0;
            end
            if (do_pop) begin
                m_cur  = mq.pop_front();
                m_busy = 1'b1;
                m_cnt  = 0;
            end
            if (wr_en && !was_full) mq.push_back(wr_data);
            if (wr_en && was_full) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        check("txd", TXD, m_txd);
        check("level", level, mq.size());
        check("full", full, (mq.size() == DEPTH) ? 1 : 0);
        check("overflow", overflow, m_ovf);
        check("tx_idle", tx_idle, (mq.size() == 0 && !m_busy) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic rx_byte(output logic [7:0] d, output int t, output bit ok);
        int n = 0;
        d  = 8'h00;
        t  = 0;
        ok = 1'b0;
        while (TXD !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        if (TXD === 1'b0) begin
            t  = cyc;
            ok = 1'b1;
            repeat (CPB / 2) step();
            if (TXD !== 1'b0) ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) step();
                d[k] = TXD;
            end
            repeat (CPB) step();
            if (TXD !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_idle !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check("wait_idle", tx_idle, 1);
    endtask

    initial begin
        logic [7:0] rx;
        int         t0;
        int         tprev;
        bit         ok;

        tbl[0] = '{1'b1, 8'h01, 1'b0, 1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h02, 1'b0, 1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h03, 1'b0, 2, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h04, 1'b0, 3, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h05, 1'b0, 4, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'h06, 1'b0, 4, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 8'h77, 1'b1, 4, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 4, 1'b1, 1'b0};

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        step();
        step();
        reset = 1'b0;
        repeat (20) step();
        check("rst_txd", TXD, 1);
        check("rst_idle", tx_idle, 1);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);

        // single byte 0xA5: start bit appears two edges after the strobe
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("a5_lvl", level, 1);
        check("a5_txd_n", TXD, 1);
        step();
        check("a5_txd_n1", TXD, 1);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CPB; j++) begin
                step();
                check("a5_bit", TXD, a5_bits[k]);
                if (k == 9 && j == CPB - 2) check("a5_busy", tx_idle, 0);
                if (k == 9 && j == CPB - 1) check("a5_idle", tx_idle, 1);
            end
        end

        // burst of six writes into a four-deep FIFO, then overflow clear collision
        for (int i = 0; i < 9; i++) begin
            wr_en   = tbl[i].wr;
            wr_data = tbl[i].data;
            clr_ovf = tbl[i].clr;
            step();
            check("tbl_level", level, tbl[i].e_level);
            check("tbl_full", full, tbl[i].e_full);
            check("tbl_ovf", overflow, tbl[i].e_ovf);
        end
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        repeat (30) step();
        tprev = 0;
        for (int b = 0; b < 4; b++) begin
            rx_byte(rx, t0, ok);
            check("rx_ok", ok, 1);
            check("rx_data", rx, 8'h02 + b);
            if (b > 0) check("rx_gap", t0 - tprev, 10 * CPB + 1);
            tprev = t0;
        end
        wait_idle();

        // reset in the middle of a data bit with two bytes still queued
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h3C + 8'(i * 8'h41);
            step();
        end
        wr_en = 1'b0;
        check("mid_level", level, 2);
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_txd", TXD, 1);
        check("mid_rst_level", level, 0);
        check("mid_rst_idle", tx_idle, 1);
        for (int i = 0; i < 60; i++) begin
            step();
            check("rst_quiet", TXD, 1);
        end

        // write lands in the same cycle as the FSM pop while two bytes are queued
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h11 * 8'(i + 1);
            step();
        end
        wr_en = 1'b0;
        repeat (39) step();
        check("same_pre_level", level, 2);
        wr_en   = 1'b1;
        wr_data = 8'h44;
        step();
        wr_en = 1'b0;
        check("same_post_level", level, 2);
        check("same_busy", tx_idle, 0);

        // randomized traffic: dense bursts first, then sparse writes
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom_range(0, (i < 750) ? 3 : 60) == 0);
            wr_data = 8'($urandom());
            clr_ovf = ($urandom_range(0, 15) == 0);
            reset   = ($urandom_range(0, 499) == 0);
            step();
        end
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        reset   = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
